// File: rtl/pe3x3_row_ctrl.sv
// Row sequencer for a pe3x3 datapath: issues three input rows per output row,
// accumulates the three partial-sum vectors and hands the finished row downstream.
module pe3x3_row_ctrl #(
    parameter int IW      = 24,
    parameter int FW      = 8,
    parameter int OUT_NUM = 9,
    parameter int MUL_LAT = 1,
    parameter int ROW_AW  = 8,
    localparam int DW     = IW + FW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ROW_AW-1:0]     num_rows,
    output logic                  busy,
    output logic                  done,
    output logic                  fmap_rd,
    output logic [ROW_AW-1:0]     fmap_raddr,
    output logic [1:0]            wht_sel,
    input  logic [OUT_NUM*DW-1:0] pe_res_i,
    output logic [OUT_NUM*DW-1:0] res_o,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [2:0]            dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_DRAIN = 3'd2,
        S_OUT   = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    localparam int TAG_D = 1 + MUL_LAT;

    state_t                  state_q, state_d;
    logic [ROW_AW-1:0]       row_q, row_d;
    logic [ROW_AW-1:0]       nrows_q, nrows_d;
    logic [1:0]              k_q, k_d;
    logic [TAG_D-1:0]        tag_vld_q;
    logic [TAG_D-1:0][1:0]   tag_k_q;
    logic [OUT_NUM*DW-1:0]   acc_q, acc_d;

    logic                    issue;
    logic [1:0]              issue_k;
    logic                    consume;
    logic [1:0]              cons_k;
    logic                    last_consumed;

    assign issue         = (state_q == S_ISSUE);
    assign issue_k       = issue ? k_q : 2'd0;
    assign consume       = tag_vld_q[TAG_D-1];
    assign cons_k        = tag_k_q[TAG_D-1];
    assign last_consumed = consume && (cons_k == 2'd2);

    // Next-state logic; the row counter advances only on the output handshake.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        nrows_d = nrows_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_rows != '0) begin
                        nrows_d = num_rows;
                        row_d   = '0;
                        k_d     = 2'd0;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_ISSUE: begin
                if (k_q == 2'd2) begin
                    k_d     = 2'd0;
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            S_DRAIN: begin
                if (last_consumed) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (res_ready) begin
                    if ((row_q + ROW_AW'(1)) == nrows_q) begin
                        state_d = S_FIN;
                    end else begin
                        row_d   = row_q + ROW_AW'(1);
                        state_d = S_ISSUE;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Lane-wise accumulate: kernel row 0 loads, rows 1 and 2 add with DW-bit wrap.
    always_comb begin
        acc_d = acc_q;
        if (consume) begin
            for (int l = 0; l < OUT_NUM; l++) begin
                if (cons_k == 2'd0) begin
                    acc_d[l*DW +: DW] = pe_res_i[l*DW +: DW];
                end else begin
                    acc_d[l*DW +: DW] = acc_q[l*DW +: DW] + pe_res_i[l*DW +: DW];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            nrows_q <= '0;
            k_q     <= 2'd0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            nrows_q <= nrows_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
        end
    end

    // Tag stage 0 lines up with PE input data; the last stage lines up with the PE result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_q <= '0;
            tag_k_q   <= '0;
        end else begin
            tag_vld_q <= {tag_vld_q[TAG_D-2:0], issue};
            tag_k_q   <= {tag_k_q[TAG_D-2:0], issue_k};
        end
    end

    // res_valid/res_ready: a row transfers on a cycle where both are high; once
    // res_valid rises, it and res_o hold unchanged until that transfer.
    assign res_valid   = (state_q == S_OUT);
    assign res_o       = res_valid ? acc_q : '0;
    assign busy        = (state_q == S_ISSUE) || (state_q == S_DRAIN) || (state_q == S_OUT);
    assign done        = (state_q == S_FIN);
    assign fmap_rd     = issue;
    assign fmap_raddr  = issue ? (row_q + ROW_AW'(k_q)) : '0;
    assign wht_sel     = tag_k_q[0];
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pe3x3_row_ctrl.sv
// Bench for pe3x3_row_ctrl: behavioural line buffer + PE model, expected-row queue,
// and directed tasks for timing, stalls, wrap, overflow and reset.
module tb_pe3x3_row_ctrl;

    localparam int IW      = 24;
    localparam int FW      = 8;
    localparam int DW      = IW + FW;
    localparam int OUT_NUM = 9;
    localparam int MUL_LAT = 1;
    localparam int ROW_AW  = 8;
    localparam int RW      = OUT_NUM * DW;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ROW_AW-1:0] num_rows;
    logic              busy;
    logic              done;
    logic              fmap_rd;
    logic [ROW_AW-1:0] fmap_raddr;
    logic [1:0]        wht_sel;
    logic [RW-1:0]     pe_res_i;
    logic [RW-1:0]     res_o;
    logic              res_valid;
    logic              res_ready;
    logic [2:0]        dbg_state_o;

    pe3x3_row_ctrl #(
        .IW(IW), .FW(FW), .OUT_NUM(OUT_NUM), .MUL_LAT(MUL_LAT), .ROW_AW(ROW_AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows),
        .busy(busy), .done(done), .fmap_rd(fmap_rd), .fmap_raddr(fmap_raddr),
        .wht_sel(wht_sel), .pe_res_i(pe_res_i), .res_o(res_o),
        .res_valid(res_valid), .res_ready(res_ready), .dbg_state_o(dbg_state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            total;
    int            bad;
    int            cyc;
    int            t0;
    int            hs_cnt;
    int            rd_in_row;
    int            done_cnt;
    int            done_cyc;
    int            hs_cyc[$];
    logic [RW-1:0] exp_q[$];
    logic [7:0]    row254_addr[3];
    int            mode;
    logic [31:0]   seed;
    logic          prev_stall;
    logic [RW-1:0] prev_res;

    // mode 0: 1.0/2.0/3.0 per kernel row; mode 1: overflow pattern; mode 2: address-dependent hash
    function automatic logic [31:0] pe_val(input int m, input logic [7:0] addr,
                                           input logic [1:0] k, input int lane,
                                           input logic [31:0] sd);
        logic [31:0] v;
        case (m)
            0: v = (32'(k) + 32'd1) << 8;
            1: v = (k == 2'd0) ? 32'h7FFF_FF00 : ((k == 2'd1) ? 32'h0000_0200 : 32'h0);
            default: v = (32'(addr) * 32'h0100_0193) ^ (32'(lane) * 32'h9E37_79B1) ^ (32'(k) << 28) ^ sd;
        endcase
        return v;
    endfunction

    function automatic logic [RW-1:0] exp_row(input int r);
        logic [7:0]    a;
        logic [31:0]   s;
        logic [RW-1:0] v;
        a = 8'(r);
        v = '0;
        for (int l = 0; l < OUT_NUM; l++) begin
            s = pe_val(mode, a, 2'd0, l, seed) + pe_val(mode, a + 8'd1, 2'd1, l, seed)
              + pe_val(mode, a + 8'd2, 2'd2, l, seed);
            v[l*DW +: DW] = s;
        end
        return v;
    endfunction

    // line buffer (1 cycle) followed by a MUL_LAT=1 PE stage
    logic        lb_vld = 1'b0;
    logic [7:0]  lb_addr = '0;
    logic        s_rd, s_lbv;
    logic [7:0]  s_addr, s_lba;
    logic [1:0]  s_wsel;
    initial pe_res_i = {OUT_NUM{32'hDEAD_BEEF}};
    always begin
        @(negedge clk);
        s_rd   = fmap_rd;
        s_addr = fmap_raddr;
        s_wsel = wht_sel;
        s_lbv  = lb_vld;
        s_lba  = lb_addr;
        @(posedge clk);
        #1;
        lb_vld  = s_rd;
        lb_addr = s_addr;
        for (int l = 0; l < OUT_NUM; l++) begin
            pe_res_i[l*DW +: DW] = s_lbv ? pe_val(mode, s_lba, s_wsel, l, seed) : 32'hDEAD_BEEF;
        end
    end

    // scoreboard / protocol monitor
    task automatic monitor();
        logic [RW-1:0] e;
        logic [7:0]    exp_a;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (fmap_rd === 1'b1) begin
                    total++;
                    if (res_valid !== 1'b0) begin
                        bad++;
                        $display("FAIL overlap: res_valid=%b during fmap_rd, required 0", res_valid);
                    end
                    if (hs_cnt == 254 && rd_in_row < 3) row254_addr[rd_in_row] = fmap_raddr;
                    exp_a = 8'(hs_cnt + rd_in_row);
                    total++;
                    if (fmap_raddr !== exp_a) begin
                        bad++;
                        $display("FAIL raddr: got %0d required %0d", fmap_raddr, exp_a);
                    end
                    rd_in_row++;
                end
                if (prev_stall) begin
                    total++;
                    if (res_valid !== 1'b1 || res_o !== prev_res) begin
                        bad++;
                        $display("FAIL hold: valid=%b res=%h required valid=1 res=%h", res_valid, res_o, prev_res);
                    end
                end
                if (res_valid === 1'b1 && res_ready === 1'b1) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_row: got %h with empty expected queue", res_o);
                    end else begin
                        e = exp_q.pop_front();
                        if (res_o !== e) begin
                            bad++;
                            $display("FAIL row%0d: got %h required %h", hs_cnt, res_o, e);
                        end
                    end
                    hs_cnt++;
                    rd_in_row = 0;
                    hs_cyc.push_back(cyc);
                end
                if (done === 1'b1) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                prev_stall = (res_valid === 1'b1) && (res_ready !== 1'b1);
                prev_res   = res_o;
            end
        end
    endtask

    // driver tasks
    task automatic launch(input int n, input int m);
        @(posedge clk);
        #1;
        mode      = m;
        seed      = $urandom;
        hs_cnt    = 0;
        rd_in_row = 0;
        done_cnt  = 0;
        hs_cyc.delete();
        for (int i = 0; i < 3; i++) row254_addr[i] = 8'h11;
        t0 = cyc + 1;
        for (int r = 0; r < n; r++) exp_q.push_back(exp_row(r));
        num_rows = ROW_AW'(n);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_tile(input int limit, input int stall_pct, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(posedge clk);
            #1;
            res_ready = ($urandom_range(0, 99) >= stall_pct);
            @(negedge clk);
            if (done_cnt > 0) seen = 1'b1;
        end
        res_ready = 1'b1;
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s_done_timeout: no done within %0d cycles, required done", name, limit);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_missing_rows: got %0d rows pending, required 0", name, exp_q.size());
        end
    endtask

    task automatic check_outputs_zero(input string name);
        total++;
        if ({busy, done, fmap_rd, res_valid} !== 4'b0 || fmap_raddr !== '0 || wht_sel !== 2'd0 || res_o !== '0) begin
            bad++;
            $display("FAIL %s: busy=%b done=%b rd=%b addr=%h ws=%h rv=%b res=%h, required all 0",
                     name, busy, done, fmap_rd, fmap_raddr, wht_sel, res_valid, res_o);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("reset_released");
    endtask

    task automatic test_single_row();
        logic [RW-1:0] e600;
        logic          e_rd, e_rv, e_done, e_busy;
        logic [7:0]    e_addr;
        logic [1:0]    e_ws;
        for (int l = 0; l < OUT_NUM; l++) e600[l*DW +: DW] = 32'h600;
        res_ready = 1'b1;
        launch(1, 0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            e_rd   = (c >= 1 && c <= 3);
            e_addr = e_rd ? 8'(c - 1) : 8'd0;
            e_ws   = (c >= 2 && c <= 4) ? 2'(c - 2) : 2'd0;
            e_rv   = (c == 6);
            e_done = (c == 7);
            e_busy = (c >= 1 && c <= 6);
            total++;
            if (fmap_rd !== e_rd || fmap_raddr !== e_addr) begin
                bad++;
                $display("FAIL single_rd c%0d: rd=%b addr=%0d required rd=%b addr=%0d", c, fmap_rd, fmap_raddr, e_rd, e_addr);
            end
            total++;
            if (wht_sel !== e_ws) begin
                bad++;
                $display("FAIL single_wht c%0d: got %0d required %0d", c, wht_sel, e_ws);
            end
            total++;
            if (res_valid !== e_rv || done !== e_done || busy !== e_busy) begin
                bad++;
                $display("FAIL single_ctl c%0d: rv=%b done=%b busy=%b required rv=%b done=%b busy=%b",
                         c, res_valid, done, busy, e_rv, e_done, e_busy);
            end
            if (c == 6) begin
                total++;
                if (res_o !== e600) begin
                    bad++;
                    $display("FAIL single_res: got %h required %h", res_o, e600);
                end
            end
        end
        total++;
        if (done_cnt != 1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL single_end: done_cnt=%0d pending=%0d required 1 and 0", done_cnt, exp_q.size());
        end
    endtask

    task automatic test_overflow();
        bit seen;
        seen = 1'b0;
        launch(1, 1);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (res_valid === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen || res_o[31:0] !== 32'h8000_0100 || res_o[8*DW +: DW] !== 32'h8000_0100) begin
            bad++;
            $display("FAIL overflow: seen=%b lane0=%h lane8=%h required 80000100", seen, res_o[31:0], res_o[8*DW +: DW]);
        end
        wait_tile(20, 0, "overflow");
    endtask

    task automatic test_zero_rows();
        launch(0, 0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            total++;
            if (done !== (c == 1) || fmap_rd !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL zero_rows c%0d: done=%b rd=%b rv=%b busy=%b required done=%b others 0",
                         c, done, fmap_rd, res_valid, busy, (c == 1));
            end
        end
        total++;
        if (done_cnt != 1) begin
            bad++;
            $display("FAIL zero_rows_done: got %0d pulses required 1", done_cnt);
        end
    endtask

    task automatic test_start_ignored();
        launch(2, 2);
        repeat (2) @(posedge clk);
        #1;
        start    = 1'b1;
        num_rows = 8'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_tile(60, 0, "start_ignored");
        repeat (10) @(negedge clk);
        total++;
        if (hs_cnt != 2 || busy !== 1'b0) begin
            bad++;
            $display("FAIL start_ignored: rows=%0d busy=%b required rows=2 busy=0", hs_cnt, busy);
        end
    endtask

    task automatic test_stall();
        bit seen;
        res_ready = 1'b1;
        launch(3, 2);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (hs_cnt >= 1) seen = 1'b1;
        end
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (res_valid === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL stall_valid_timeout: res_valid=%b required 1", res_valid);
        end
        repeat (3) begin
            @(negedge clk);
            total++;
            if (hs_cnt != 1 || res_valid !== 1'b1) begin
                bad++;
                $display("FAIL stall_wait: rows=%0d rv=%b required rows=1 rv=1", hs_cnt, res_valid);
            end
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        wait_tile(60, 0, "stall");
        total++;
        if (hs_cnt != 3) begin
            bad++;
            $display("FAIL stall_rows: got %0d required 3", hs_cnt);
        end
    endtask

    task automatic test_back_to_back();
        launch(4, 2);
        wait_tile(60, 0, "b2b");
        total++;
        if (hs_cyc.size() != 4) begin
            bad++;
            $display("FAIL b2b_count: got %0d required 4", hs_cyc.size());
        end else begin
            total++;
            if (hs_cyc[0] - t0 != 5 + MUL_LAT) begin
                bad++;
                $display("FAIL b2b_first: got cycle %0d required %0d", hs_cyc[0] - t0, 5 + MUL_LAT);
            end
            for (int i = 1; i < 4; i++) begin
                total++;
                if (hs_cyc[i] - hs_cyc[i-1] != 5 + MUL_LAT) begin
                    bad++;
                    $display("FAIL b2b_period%0d: got %0d required %0d", i, hs_cyc[i] - hs_cyc[i-1], 5 + MUL_LAT);
                end
            end
            total++;
            if (done_cyc - hs_cyc[3] != 1) begin
                bad++;
                $display("FAIL b2b_done: got %0d cycles after last row required 1", done_cyc - hs_cyc[3]);
            end
        end
    endtask

    task automatic test_addr_wrap();
        logic [7:0] e_addr[3];
        e_addr[0] = 8'd254;
        e_addr[1] = 8'd255;
        e_addr[2] = 8'd0;
        launch(255, 2);
        wait_tile(4000, 25, "wrap");
        for (int i = 0; i < 3; i++) begin
            total++;
            if (row254_addr[i] !== e_addr[i]) begin
                bad++;
                $display("FAIL wrap_addr%0d: got %0d required %0d", i, row254_addr[i], e_addr[i]);
            end
        end
    endtask

    task automatic test_reset_drain();
        res_ready = 1'b1;
        launch(2, 2);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1 || fmap_rd !== 1'b0 || res_valid !== 1'b0) begin
            bad++;
            $display("FAIL pre_drain: busy=%b rd=%b rv=%b required 1 0 0", busy, fmap_rd, res_valid);
        end
        rst_n = 1'b0;
        #1;
        check_outputs_zero("reset_drain");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("after_release");
        launch(1, 2);
        wait_tile(30, 0, "post_reset");
        total++;
        if (hs_cnt != 1) begin
            bad++;
            $display("FAIL post_reset_rows: got %0d required 1", hs_cnt);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        num_rows   = '0;
        res_ready  = 1'b1;
        total      = 0;
        bad        = 0;
        cyc        = 0;
        hs_cnt     = 0;
        rd_in_row  = 0;
        done_cnt   = 0;
        done_cyc   = 0;
        mode       = 0;
        seed       = '0;
        prev_stall = 1'b0;
        prev_res   = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_single_row();
        test_overflow();
        test_zero_rows();
        test_start_ignored();
        test_stall();
        test_back_to_back();
        test_addr_wrap();
        test_reset_drain();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL final_queue: got %0d pending rows required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pe3x3_row_ctrl.md
# pe3x3_row_ctrl

Sequencer that drives one `pe3x3` datapath through a full 3x3 convolution of a feature-map tile, one output row at a time. For each output row it issues the three input rows (kernel rows 0..2) to the PE with the matching weight-row select, and accumulates the three 9-lane partial-sum vectors returned by the PE. It then presents the finished row to the downstream writer over a valid/ready handshake. It sits between the line buffer and weight store on one side and the PE and output writer on the other.

## Interface
Parameters:
- `IW`, 24, integer bits of Q format
- `FW`, 8, fraction bits; data width `DW = IW+FW`
- `OUT_NUM`, 9, PE output lanes
- `MUL_LAT`, 1, PE multiplier latency in cycles (>=1)
- `ROW_AW`, 8, row address / row count width

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin tile; sampled only in IDLE
- `num_rows`  in  ROW_AW  output rows N; latched on accepted `start`
- `busy`  out  1  tile in progress
- `done`  out  1  one-cycle pulse at tile end
- `fmap_rd`  out  1  line-buffer row read strobe; data appears at PE input next cycle
- `fmap_raddr`  out  ROW_AW  input row address, valid with `fmap_rd`
- `wht_sel`  out  2  kernel row selecting the PE weight row; aligned with the PE input data, i.e. one cycle after `fmap_rd`
- `pe_res_i`  in  OUT_NUM*DW  PE result vector, lane k at bits [k*DW +: DW]
- `res_o`  out  OUT_NUM*DW  accumulated row
- `res_valid`  out  1  `res_o` valid
- `res_ready`  in  1  downstream accept

## Operation
- States: IDLE, ISSUE, DRAIN, OUT, FIN.
- IDLE: on `start` with N>0, latch N, set row r=0, go to ISSUE. On `start` with N==0, go to FIN (no reads, no results).
- ISSUE: three consecutive cycles with `fmap_rd`=1 and `fmap_raddr` = r+k for k=0,1,2. The address is mod 2^ROW_AW; wrap is allowed, not an error. After k=2, go to DRAIN.
- Tag pipeline: a shift register of depth 1+MUL_LAT carries {valid, k}. `wht_sel` is the tag at stage 1. The PE result is consumed when the tag reaches stage 1+MUL_LAT.
- Accumulate, lane-wise at consume: k==0 loads `pe_res_i`; k==1 and k==2 add `pe_res_i` to the accumulator.
- Arithmetic: DW-bit two's-complement add, wrap on overflow, no saturation, no rescaling. Products are already Q24.8.
- DRAIN: when the k==2 result has been consumed, go to OUT.
- OUT: `res_valid`=1, `res_o` = accumulator, held stable until `res_ready`. On handshake, r+1 == N goes to FIN; otherwise r increments and the block returns to ISSUE on the next cycle.
- FIN: `done`=1 for one cycle, then IDLE.
- `busy`=1 in ISSUE, DRAIN and OUT. `busy`=0 in IDLE and FIN.
- `start` outside IDLE is ignored. `num_rows` changes after latch have no effect.
- Reset (any time, including mid-row): state IDLE, tag pipeline cleared, accumulator 0. All outputs 0: `busy`, `done`, `fmap_rd`, `fmap_raddr`, `wht_sel`, `res_o`, `res_valid`. No partial row is emitted after reset release.

## Timing
- Cycle 0 is `start` high in IDLE. ISSUE occupies cycles 1,2,3.
- `wht_sel` = 0,1,2 at cycles 2,3,4.
- Results are consumed at cycles 2+MUL_LAT, 3+MUL_LAT, 4+MUL_LAT.
- `res_valid` first rises at cycle 5+MUL_LAT (cycle 6 for MUL_LAT=1).
- Row-to-row: ISSUE for row r+1 begins the cycle after the row-r handshake; rows do not overlap. Row period is 5+MUL_LAT cycles with `res_ready` tied high.
- `done` asserts the cycle after the final handshake. With N==0, `done` asserts at cycle 1.
- `res_valid` never deasserts without a handshake. `res_o` is unchanged while `res_valid`=1 and `res_ready`=0.

## Test plan
- N=1, MUL_LAT=1, PE model returns lane values 1.0, 2.0 and 3.0 (0x100, 0x200, 0x300) for k=0,1,2 -> reads at addresses 0,1,2 in cycles 1..3; `wht_sel` 0,1,2 in cycles 2..4; `res_valid` at cycle 6 with every lane 0x600; `done` at cycle 7.
- N=3, `res_ready` held low 4 cycles on row 1 -> `res_o` stable throughout; row 2 reads addresses 2,3,4 only after the handshake; exactly 3 results, then `done`.
- Overflow: lanes 0x7FFFFF00 + 0x200 + 0 -> lane result 0x80000100 (wrap, no saturation).
- `start` with N=0 -> `done` at cycle 1, no `fmap_rd`, no `res_valid`. A `start` pulse while busy -> ignored, N unchanged.
- ROW_AW=8, row r=254 -> addresses 254, 255, 0.
- `rst_n` low during DRAIN -> all outputs 0 immediately. After release, a new `start` produces a correct first row with no stale accumulation.
